funcion_programable: RTL and testbench

Registered, parametrised N-input boolean function block: a 2^N-entry truth table, reloadable serially at run time, drives a registered output Y. It also contains a self-sweep sequencer that steps the select through every input combination with a programmable dwell, so lab benches and on-board demos can exercise the function without external stimulus. It sits between the switch/select inputs and the LED/output logic of the lab designs, in place of fixed combinational functions.

---
 rtl/funcion_programable.sv | 203 ++++++++++++++++++++
 tb/tb_funcion_programable.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/funcion_programable.sv
// funcion_programable: registered N-input boolean function driven by a 2^N-entry truth
// table. The table can be reloaded serially at run time, most significant entry first.
// Defining FUNC_SWEEP_EN adds a self-sweep sequencer. It steps the select through every
// input combination and holds each value for DWELL cycles.
// Without FUNC_SWEEP_EN, sweep_start is ignored and sweep_busy is tied low.

module funcion_programable #(
  parameter int unsigned         N          = 2,
  parameter logic [(1<<N)-1:0]   TABLE_INIT = 4'b0110,
  parameter int unsigned         DWELL      = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] S,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic         sweep_start,
  output logic         Y,
  output logic         Y_valid,
  output logic [N-1:0] idx,
  output logic         load_done,
  output logic         sweep_busy
);

  localparam int unsigned Depth   = 1 << N;
  localparam logic [N:0]  LastBit = (N+1)'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSweep} state_e;

  state_e             stateQ, stateD;
  logic [Depth-1:0]   tblQ, tblD;
  logic [Depth-1:0]   shadowQ, shadowD;
  logic [Depth-1:0]   shiftVal;
  logic [N:0]         loadCntQ, loadCntD;
  logic               yQ, yD;
  logic               yValidQ, yValidD;
  logic [N-1:0]       idxQ, idxD;
  logic               loadDoneQ, loadDoneD;

`ifdef FUNC_SWEEP_EN
  localparam int unsigned       DwellW    = $clog2(DWELL + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);
  localparam logic [N-1:0]      IdxLast   = {N{1'b1}};

  logic [DwellW-1:0]  dwellQ, dwellD;
  logic [N-1:0]       idxNext;

  assign idxNext = idxQ + 1'b1;
`else
  logic unusedSweepStart;
  assign unusedSweepStart = sweep_start;
`endif

  // The first bit sent ends up in the MSB, so entry 2^N-1 is loaded first.
  assign shiftVal = {shadowQ[Depth-2:0], load_bit};

  // Next-state logic: load_en wins over sweep_start in IDLE.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle: begin
        if (load_en) begin
          stateD = StLoad;
`ifdef FUNC_SWEEP_EN
        end else if (sweep_start) begin
          stateD = StSweep;
`endif
        end
      end
      StLoad: begin
        // Either the last bit is being captured or load_en dropped early (abort).
        if (!load_en || (loadCntQ == LastBit)) begin
          stateD = StIdle;
        end
      end
`ifdef FUNC_SWEEP_EN
      StSweep: begin
        if ((dwellQ == DwellLast) && (idxQ == IdxLast)) begin
          stateD = StIdle;
        end
      end
`endif
      default: stateD = StIdle;
    endcase
  end

  // Datapath next values: table, shadow, counters and the registered outputs.
  always_comb begin
    tblD      = tblQ;
    shadowD   = shadowQ;
    loadCntD  = loadCntQ;
    yD        = yQ;
    yValidD   = yValidQ;
    idxD      = idxQ;
    loadDoneD = 1'b0;
`ifdef FUNC_SWEEP_EN
    dwellD    = dwellQ;
`endif
    case (stateQ)
      StIdle: begin
        if (load_en) begin
          // The edge that enters LOAD also captures bit 0. Y holds its value.
          shadowD  = shiftVal;
          loadCntD = {{N{1'b0}}, 1'b1};
          yValidD  = 1'b0;
`ifdef FUNC_SWEEP_EN
        end else if (sweep_start) begin
          // idx=0 and Y=T[0] are valid in the first sweep cycle.
          idxD    = '0;
          yD      = tblQ[0];
          yValidD = 1'b1;
          dwellD  = '0;
`endif
        end else begin
          idxD    = S;
          yD      = tblQ[S];
          yValidD = 1'b1;
        end
      end
      StLoad: begin
        yValidD = 1'b0;
        if (load_en) begin
          shadowD = shiftVal;
          if (loadCntQ == LastBit) begin
            tblD      = shiftVal;
            loadDoneD = 1'b1;
            loadCntD  = '0;
          end else begin
            loadCntD = loadCntQ + 1'b1;
          end
        end else begin
          // Abort: the table is untouched and the partial shadow is left to be overwritten.
          loadCntD = '0;
        end
      end
`ifdef FUNC_SWEEP_EN
      StSweep: begin
        if (dwellQ == DwellLast) begin
          dwellD = '0;
          // On the final dwell idx/Y hold. IDLE tracking starts on the following edge.
          if (idxQ != IdxLast) begin
            idxD = idxNext;
            yD   = tblQ[idxNext];
          end
        end else begin
          dwellD = dwellQ + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Datapath registers. Reset restores the initial table and clears everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tblQ      <= TABLE_INIT;
      shadowQ   <= '0;
      loadCntQ  <= '0;
      yQ        <= 1'b0;
      yValidQ   <= 1'b0;
      idxQ      <= '0;
      loadDoneQ <= 1'b0;
`ifdef FUNC_SWEEP_EN
      dwellQ    <= '0;
`endif
    end else begin
      tblQ      <= tblD;
      shadowQ   <= shadowD;
      loadCntQ  <= loadCntD;
      yQ        <= yD;
      yValidQ   <= yValidD;
      idxQ      <= idxD;
      loadDoneQ <= loadDoneD;
`ifdef FUNC_SWEEP_EN
      dwellQ    <= dwellD;
`endif
    end
  end

  // Output logic: registered values plus the sweep indicator decoded from the state.
  always_comb begin
    Y         = yQ;
    Y_valid   = yValidQ;
    idx       = idxQ;
    load_done = loadDoneQ;
`ifdef FUNC_SWEEP_EN
    sweep_busy = (stateQ == StSweep);
`else
    sweep_busy = 1'b0;
`endif
  end

endmodule

// File: tb/tb_funcion_programable.sv
// Testbench for funcion_programable.
// Expected outputs are derived per transaction (idle cycle, serial load, sweep) and
// queued. A monitor pops and compares one entry after each clock edge.

module tb_funcion_programable;

  localparam int       N     = 2;
  localparam int       Depth = 4;
  localparam int       Dw    = 20;
  localparam logic [3:0] Init = 4'b0110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] S;
  logic         load_en;
  logic         load_bit;
  logic         sweep_start;
  logic         Y;
  logic         Y_valid;
  logic [N-1:0] idx;
  logic         load_done;
  logic         sweep_busy;

  funcion_programable #(
    .N          (N),
    .TABLE_INIT (Init),
    .DWELL      (Dw)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .S           (S),
    .load_en     (load_en),
    .load_bit    (load_bit),
    .sweep_start (sweep_start),
    .Y           (Y),
    .Y_valid     (Y_valid),
    .idx         (idx),
    .load_done   (load_done),
    .sweep_busy  (sweep_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N+3:0] v;
    string        tag;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: the committed table plus the last Y/idx presented.
  logic [Depth-1:0] mT;
  logic             mY;
  logic [N-1:0]     mIdx;

  function automatic logic [N+3:0] pack(logic y, logic v, logic [N-1:0] i, logic ld, logic b);
    return {y, v, i, ld, b};
  endfunction

  function automatic void pushExp(logic y, logic v, logic [N-1:0] i, logic ld, logic b,
                                  string tag);
    exp_t e;
    e.v   = pack(y, v, i, ld, b);
    e.tag = tag;
    expQ.push_back(e);
  endfunction

  task automatic checkNow(input logic [N+3:0] e, input string tag);
    logic [N+3:0] got;
    got = pack(Y, Y_valid, idx, load_done, sweep_busy);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: {Y,Y_valid,idx,load_done,sweep_busy} got %b required %b", tag, got, e);
    end
  endtask

  // Monitor: one comparison per edge whenever an expectation is pending.
  initial begin
    forever begin
      exp_t         e;
      logic [N+3:0] got;
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e   = expQ.pop_front();
        got = pack(Y, Y_valid, idx, load_done, sweep_busy);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s @%0t: {Y,Y_valid,idx,load_done,sweep_busy} got %b required %b",
                   e.tag, $time, got, e.v);
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] s, input logic le, input logic lb, input logic ss);
    @(negedge clk);
    S           = s;
    load_en     = le;
    load_bit    = lb;
    sweep_start = ss;
  endtask

  // One IDLE cycle: Y follows T[S] and idx follows S.
  task automatic idleCyc(input logic [N-1:0] s, input logic ss, input string tag);
    cyc(s, 1'b0, 1'($urandom()), ss);
    mY   = mT[s];
    mIdx = s;
    pushExp(mY, 1'b1, mIdx, 1'b0, 1'b0, tag);
  endtask

  // Serial load of nb bits from bits (MSB first). Fewer than Depth bits means an abort.
  task automatic loadSeq(input logic [Depth-1:0] bits, input int nb, input logic ss0,
                         input string tag);
    for (int j = 0; j < nb; j++) begin
      cyc(N'($urandom()), 1'b1, bits[Depth-1-j], (j == 0) ? ss0 : 1'b0);
      if (j == Depth - 1) begin
        mT = bits;
        pushExp(mY, 1'b0, mIdx, 1'b1, 1'b0, {tag, " commit"});
      end else begin
        pushExp(mY, 1'b0, mIdx, 1'b0, 1'b0, tag);
      end
    end
    if (nb < Depth) begin
      cyc(N'($urandom()), 1'b0, 1'($urandom()), 1'b0);
      pushExp(mY, 1'b0, mIdx, 1'b0, 1'b0, {tag, " abort"});
    end
  endtask

`ifdef FUNC_SWEEP_EN
  // Sweep: idx = cycle/DWELL while busy. On the last edge outputs hold and busy drops.
  // A positive stopAt ends the stimulus early, before edge stopAt.
  task automatic sweep(input int stopAt, input string tag);
    cyc(N'($urandom()), 1'b0, 1'b0, 1'b1);
    mIdx = '0;
    mY   = mT[0];
    pushExp(mY, 1'b1, mIdx, 1'b0, 1'b1, tag);
    for (int j = 1; j <= Depth * Dw; j++) begin
      if (j == stopAt) return;
      cyc(N'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
      if (j < Depth * Dw) begin
        mIdx = N'(j / Dw);
        mY   = mT[mIdx];
        pushExp(mY, 1'b1, mIdx, 1'b0, 1'b1, tag);
      end else begin
        pushExp(mY, 1'b1, mIdx, 1'b0, 1'b0, {tag, " end"});
      end
    end
  endtask
`endif

  // Asynchronous reset away from a clock edge, checked immediately.
  task automatic resetPulse(input string tag);
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    load_en     = 1'b0;
    sweep_start = 1'b0;
    #1;
    checkNow(pack(1'b0, 1'b0, '0, 1'b0, 1'b0), tag);
    mT   = Init;
    mY   = 1'b0;
    mIdx = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [Depth-1:0] rt;
    rst_n       = 1'b0;
    S           = '0;
    load_en     = 1'b0;
    load_bit    = 1'b0;
    sweep_start = 1'b0;
    mT          = Init;
    mY          = 1'b0;
    mIdx        = '0;
    #12;
    checkNow(pack(1'b0, 1'b0, '0, 1'b0, 1'b0), "reset state");
    @(negedge clk);
    rst_n = 1'b1;

    // Default XOR table, each select held for 20 cycles.
    for (int s = 0; s < Depth; s++) begin
      for (int k = 0; k < 20; k++) idleCyc(N'(s), 1'b0, "xor track");
    end

    // Aborted load leaves the table alone.
    loadSeq(4'b1000, 2, 1'b0, "abort load");
    for (int k = 0; k < 3; k++) idleCyc(2'd1, 1'b0, "after abort S=1");

    // AND table.
    loadSeq(4'b1000, Depth, 1'b0, "and load");
    for (int k = 0; k < 3; k++) idleCyc(2'd3, 1'b0, "and S=3");
    for (int k = 0; k < 3; k++) idleCyc(2'd1, 1'b0, "and S=1");

    // Random tables, random aborts, random selects.
    for (int r = 0; r < 8; r++) begin
      rt = Depth'($urandom());
      if ($urandom_range(0, 3) == 0) loadSeq(rt, $urandom_range(1, Depth - 1), 1'b0, "rand abort");
      else loadSeq(rt, Depth, 1'b0, "rand load");
      for (int k = 0; k < 8; k++) idleCyc(N'($urandom()), 1'b0, "rand idle");
    end

    // load_en and sweep_start together: LOAD wins, no sweep.
    loadSeq(4'b0110, Depth, 1'b1, "collision load");
    for (int k = 0; k < 4; k++) idleCyc(N'($urandom()), 1'b0, "after collision");

`ifdef FUNC_SWEEP_EN
    sweep(-1, "sweep xor");
    for (int k = 0; k < 6; k++) idleCyc(N'($urandom()), 1'b0, "after sweep");
    loadSeq(4'b1011, Depth, 1'b0, "pre-sweep load");
    sweep(-1, "sweep 1011");
    for (int k = 0; k < 4; k++) idleCyc(N'($urandom()), 1'b0, "after sweep 2");
    loadSeq(4'b1000, Depth, 1'b0, "pre-reset load");
    sweep(30, "sweep cut");
    resetPulse("reset mid-sweep");
`else
    idleCyc(2'd2, 1'b1, "sweep_start ignored");
    for (int k = 0; k < 6; k++) idleCyc(N'($urandom()), 1'b0, "after ignored start");
    loadSeq(4'b1000, Depth, 1'b0, "pre-reset load");
    resetPulse("reset in idle");
`endif
    for (int s = 0; s < Depth; s++) begin
      for (int k = 0; k < 2; k++) idleCyc(N'(s), 1'b0, "init table after reset");
    end

    for (int k = 0; k < 10 && expQ.size() != 0; k++) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
